// File: rtl/conv_pkg.sv
// Shared types and constants for the conv engine sequencer.
// State enum, pixel/kernel widths, flush length, input depth helper.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_D,
    COMPUTE,
    FLUSH,
    DONE
  } state_e;

  localparam int PIX_W        = 6;
  localparam int KERNEL_W     = 9;
  localparam int FLUSH_CYCLES = 4;

  function automatic int input_depth(
    input int size,
    input int ti,
    input int ch
  );
    return 4 * (ch / ti) * size;
  endfunction

endpackage

// File: rtl/conv_seq_rd_issue.sv
// Burst read issuer: base/length address generator with a 1-cycle return flag.
// Ports: go_i/base_i/len_i start a burst, stall_i pauses issue; rd_en_o/rd_addr_o to SRAM, ret_o/ret_last_o mark returns.
module conv_seq_rd_issue
  import conv_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              stall_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              ret_o,
  output logic              ret_last_o
);

  logic [LEN_W-1:0]  pend_q, pend_d, pend_w;
  logic [ADDR_W-1:0] nxt_q, nxt_d, nxt_w;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              last_q, last_d;
  logic              ret_q, ret_last_q;

  // go_i takes effect in the same cycle so the first read
  // lands on the cycle the phase begins.
  always_comb begin
    pend_w = go_i ? len_i : pend_q;
    nxt_w  = go_i ? base_i : nxt_q;
    en_d   = (pend_w != '0) && !stall_i;
    pend_d = pend_w;
    nxt_d  = nxt_w;
    addr_d = addr_q;
    last_d = last_q;
    if (en_d) begin
      addr_d = nxt_w;
      nxt_d  = nxt_w + ADDR_W'(1);
      pend_d = pend_w - LEN_W'(1);
      last_d = (pend_w == LEN_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      nxt_q      <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      last_q     <= 1'b0;
      ret_q      <= 1'b0;
      ret_last_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      nxt_q      <= nxt_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
      last_q     <= last_d;
      ret_q      <= en_q;
      ret_last_q <= en_q & last_q;
    end
  end

  assign rd_en_o    = en_q;
  assign rd_addr_o  = addr_q;
  assign ret_o      = ret_q;
  assign ret_last_o = ret_last_q;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Job sequencer for the ternary 3x3 conv engine: load weights, load data, compute, flush, done.
// Ports: host start/bases/compute_cycles, busy/done/out_count; SRAM rd_*; engine weight/data/compute. Macro CONV_SEQ_CTRL_HOLD_EN adds hold.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int INPUT_SIZE    = 16,
  parameter int TI            = 3,
  parameter int INPUT_CHANNEL = 3,
  parameter int ADDR_W        = 12,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   w_base,
  input  logic [ADDR_W-1:0]   d_base,
  input  logic [CNT_W-1:0]    compute_cycles,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    out_count,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [6*TI-1:0]     rd_data,
  output logic [KERNEL_W-1:0] weight_in,
  output logic                buffer_weight_fire,
  output logic [6*TI-1:0]     data_in,
  output logic                buffer_data_fire,
  output logic                compute_fire,
`ifdef CONV_SEQ_CTRL_HOLD_EN
  input  logic                hold,
`endif
  input  logic                compute_done
);

  localparam int DEPTH = input_depth(INPUT_SIZE, TI, INPUT_CHANNEL);
  localparam int LEN_W = $clog2(DEPTH + TI + 1);
  localparam int FL_W  = $clog2(FLUSH_CYCLES);
  localparam int DW    = PIX_W * TI;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  oc_q, oc_d;
  logic [ADDR_W-1:0] dbase_q, dbase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, rem;
  logic [FL_W-1:0]   fl_q, fl_d;
  logic [KERNEL_W-1:0] wt_q, wt_d;
  logic              wf_q, wf_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic              df_q, df_d;
  logic              cf_q, cf_d;

  logic              go;
  logic [ADDR_W-1:0] go_base;
  logic [LEN_W-1:0]  go_len;
  logic              stall;
  logic              ret, ret_last;
  logic              hold_w;

`ifdef CONV_SEQ_CTRL_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  assign stall = hold_w && (state_q == LOAD_D);

  conv_seq_rd_issue #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_issue (
    .clk        (clk),
    .rst        (rst),
    .go_i       (go),
    .base_i     (go_base),
    .len_i      (go_len),
    .stall_i    (stall),
    .rd_en_o    (rd_en),
    .rd_addr_o  (rd_addr),
    .ret_o      (ret),
    .ret_last_o (ret_last)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbase_d = dbase_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    cf_d    = 1'b0;
    go      = 1'b0;
    go_base = '0;
    go_len  = '0;
    rem     = cnt_q - CNT_W'(cf_q);
    wf_d    = ret && (state_q == LOAD_W);
    df_d    = ret && (state_q == LOAD_D);
    wt_d    = wf_d ? rd_data[KERNEL_W-1:0] : wt_q;
    dat_d   = df_d ? rd_data : dat_q;
    oc_d    = oc_q;
    if (state_q != IDLE && compute_done && !(&oc_q))
      oc_d = oc_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          busy_d  = 1'b1;
          oc_d    = '0;
          dbase_d = d_base;
          cnt_d   = (compute_cycles == '0) ?
                    CNT_W'(1) : compute_cycles;
          go      = 1'b1;
          go_base = w_base;
          go_len  = LEN_W'(TI);
        end
      end
      LOAD_W: begin
        if (ret_last) begin
          state_d = LOAD_D;
          go      = 1'b1;
          go_base = dbase_q;
          go_len  = LEN_W'(DEPTH);
        end
      end
      LOAD_D: begin
        if (ret_last) begin
          state_d = COMPUTE;
          cf_d    = !hold_w;
        end
      end
      COMPUTE: begin
        // cnt_q counts fire cycles still owed, including this one.
        if (rem == '0) begin
          state_d = FLUSH;
          fl_d    = '0;
        end else begin
          cnt_d = rem;
          cf_d  = !hold_w;
        end
      end
      FLUSH: begin
        if (fl_q == FL_W'(FLUSH_CYCLES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          fl_d = fl_q + FL_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oc_q    <= '0;
      dbase_q <= '0;
      cnt_q   <= '0;
      fl_q    <= '0;
      wt_q    <= '0;
      wf_q    <= 1'b0;
      dat_q   <= '0;
      df_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      oc_q    <= oc_d;
      dbase_q <= dbase_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      wt_q    <= wt_d;
      wf_q    <= wf_d;
      dat_q   <= dat_d;
      df_q    <= df_d;
      cf_q    <= cf_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign out_count          = oc_q;
  assign weight_in          = wt_q;
  assign buffer_weight_fire = wf_q;
  assign data_in            = dat_q;
  assign buffer_data_fire   = df_q;
  assign compute_fire       = cf_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl with an SRAM model and a simple engine model.
// Optional hold scenario compiled only with CONV_SEQ_CTRL_HOLD_EN.
module tb_conv_seq_ctrl;

  localparam int AW    = 12;
  localparam int CW    = 16;
  localparam int DW    = 18;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] w_base, d_base;
  logic [CW-1:0] compute_cycles;
  logic          busy, done;
  logic [CW-1:0] out_count;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [8:0]    weight_in;
  logic          buffer_weight_fire;
  logic [DW-1:0] data_in;
  logic          buffer_data_fire;
  logic          compute_fire;
  logic          compute_done;
`ifdef CONV_SEQ_CTRL_HOLD_EN
  logic          hold;
`endif

  int n_vec = 0;
  int n_err = 0;
  int base_len = 84;

  conv_seq_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .w_base             (w_base),
    .d_base             (d_base),
    .compute_cycles     (compute_cycles),
    .busy               (busy),
    .done               (done),
    .out_count          (out_count),
    .rd_en              (rd_en),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .weight_in          (weight_in),
    .buffer_weight_fire (buffer_weight_fire),
    .data_in            (data_in),
    .buffer_data_fire   (buffer_data_fire),
    .compute_fire       (compute_fire),
`ifdef CONV_SEQ_CTRL_HOLD_EN
    .hold               (hold),
`endif
    .compute_done       (compute_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {a, a[5:0] ^ 6'h25};
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem_f(rd_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] aq[$];
  logic [8:0]    wq[$];
  logic [DW-1:0] dq[$];
  int cf_n, done_n, ovl_n, cf_first, cf_last, done_cyc;
  logic done_busy;
  logic [CW-1:0] done_oc;

  always @(negedge clk) begin
    if (rd_en) aq.push_back(rd_addr);
    if (buffer_weight_fire) wq.push_back(weight_in);
    if (buffer_data_fire) dq.push_back(data_in);
    if (buffer_weight_fire && buffer_data_fire) ovl_n++;
    if (compute_fire) begin
      if (cf_n == 0) cf_first = cyc;
      cf_last = cyc;
      cf_n++;
    end
    if (done) begin
      done_n++;
      done_cyc  = cyc;
      done_busy = busy;
      done_oc   = out_count;
    end
  end

  task automatic clear_mon;
    aq.delete(); wq.delete(); dq.delete();
    cf_n = 0; done_n = 0; ovl_n = 0;
    cf_first = 0; cf_last = 0; done_cyc = 0;
  endtask

  task automatic run_job(
    input  logic [AW-1:0] wb,
    input  logic [AW-1:0] db,
    input  logic [CW-1:0] cc,
    input  bit            eng,
    input  bit            poke,
    input  int            hold_at,
    output bit            to,
    output int            t0,
    output logic          busy1
  );
    int fc, hc;
    bit fl_poked;
    clear_mon();
    @(negedge clk);
    w_base = wb; d_base = db; compute_cycles = cc; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    fc = 0; hc = 0; fl_poked = 0; to = 1;
    for (int i = 0; i < 1000; i++) begin
      compute_done = 1'b0;
      start = 1'b0;
      if (done) begin
        to = 0;
        break;
      end
      if (compute_fire) begin
        fc++;
        if (eng && (fc % 2 == 0)) compute_done = 1'b1;
      end else if (eng && fc >= 1 && !fl_poked) begin
        compute_done = 1'b1;
        fl_poked = 1;
      end
      if (poke && (i == 10 || (compute_fire && fc == 3))) begin
        start = 1'b1;
        w_base = 12'h777; d_base = 12'h555; compute_cycles = 16'd3;
      end
`ifdef CONV_SEQ_CTRL_HOLD_EN
      if (hold_at > 0 && fc == hold_at && hc < 5) begin
        hold = 1'b1;
        hc++;
      end else begin
        hold = 1'b0;
      end
`else
      if (hold_at > 0) hc++;
`endif
      @(negedge clk);
    end
    compute_done = 1'b0;
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, rd_en, buffer_weight_fire, buffer_data_fire, compute_fire} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, rd_en, buffer_weight_fire, buffer_data_fire, compute_fire});
    end
    n_vec++;
    if (out_count !== '0 || rd_addr !== '0) begin
      n_err++;
      $display("FAIL reset_cnt_addr: got %0d/%0h expected 0/0", out_count, rd_addr);
    end
    n_vec++;
    if (weight_in !== '0 || data_in !== '0) begin
      n_err++;
      $display("FAIL reset_words: got %0h/%0h expected 0/0", weight_in, data_in);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit to; int t0; logic b1; int bad; logic [DW-1:0] e;
    run_job(12'h100, 12'h200, 16'd10, 0, 0, 0, to, t0, b1);
    n_vec++;
    if (to) begin n_err++; $display("FAIL basic_timeout: got no done expected done"); end
    n_vec++;
    if (b1 !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise: got %b expected 1", b1); end
    n_vec++;
    if (aq.size() !== 3 + DEPTH) begin
      n_err++; $display("FAIL basic_nreads: got %0d expected %0d", aq.size(), 3 + DEPTH);
    end else begin
      bad = 0;
      for (int i = 0; i < 3; i++) if (aq[i] !== AW'(12'h100 + i)) bad++;
      if (aq[3] !== 12'h200) bad++;
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL basic_waddr: got %0d bad expected 0", bad); end
    end
    n_vec++;
    if (wq.size() !== 3) begin
      n_err++; $display("FAIL basic_wfire: got %0d expected 3", wq.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 3; i++) begin
        e = mem_f(AW'(12'h100 + i));
        if (wq[i] !== e[8:0]) bad++;
      end
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL basic_wdata: got %0d bad expected 0", bad); end
    end
    n_vec++;
    if (dq.size() !== DEPTH) begin
      n_err++; $display("FAIL basic_dfire: got %0d expected %0d", dq.size(), DEPTH);
    end else begin
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (dq[i] !== mem_f(AW'(12'h200 + i))) bad++;
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL basic_ddata: got %0d bad expected 0", bad); end
    end
    n_vec++;
    if (cf_n !== 10 || cf_last - cf_first + 1 !== 10) begin
      n_err++; $display("FAIL basic_cfire: got %0d/%0d expected 10/10", cf_n, cf_last - cf_first + 1);
    end
    n_vec++;
    if (cf_first - t0 !== 70) begin
      n_err++; $display("FAIL basic_cf_start: got %0d expected 70", cf_first - t0);
    end
    n_vec++;
    if (done_cyc - cf_last !== 5 || done_cyc - t0 !== 84) begin
      n_err++; $display("FAIL basic_done_time: got %0d/%0d expected 5/84", done_cyc - cf_last, done_cyc - t0);
    end
    base_len = done_cyc - t0;
    n_vec++;
    if (done_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b expected 0", done_busy); end
    n_vec++;
    if (ovl_n !== 0) begin n_err++; $display("FAIL basic_fire_overlap: got %0d expected 0", ovl_n); end
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done_n !== 1) begin
      n_err++; $display("FAIL basic_after: got busy %b done %0d expected 0/1", busy, done_n);
    end
  endtask

  task automatic test_out_count;
    bit to; int t0; logic b1;
    run_job(12'h010, 12'h400, 16'd20, 1, 0, 0, to, t0, b1);
    n_vec++;
    if (to) begin n_err++; $display("FAIL oc_timeout: got no done expected done"); end
    n_vec++;
    if (done_oc !== 16'd11) begin n_err++; $display("FAIL oc_at_done: got %0d expected 11", done_oc); end
    repeat (4) @(negedge clk);
    n_vec++;
    if (out_count !== 16'd11) begin n_err++; $display("FAIL oc_held: got %0d expected 11", out_count); end
  endtask

  task automatic test_wrap;
    bit to; int t0; logic b1; int bad;
    run_job(12'h000, 12'hFF0, 16'd2, 0, 0, 0, to, t0, b1);
    n_vec++;
    if (to || aq.size() !== 3 + DEPTH) begin
      n_err++; $display("FAIL wrap_reads: got %0d expected %0d", aq.size(), 3 + DEPTH);
    end else begin
      n_vec++;
      if (aq[18] !== 12'hFFF || aq[19] !== 12'h000 || aq[66] !== 12'h02F) begin
        n_err++; $display("FAIL wrap_edge: got %0h/%0h/%0h expected fff/0/2f", aq[18], aq[19], aq[66]);
      end
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (aq[3+i] !== AW'(12'hFF0 + i)) bad++;
      for (int i = 0; i < dq.size(); i++) if (dq[i] !== mem_f(AW'(12'hFF0 + i))) bad++;
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL wrap_seq: got %0d bad expected 0", bad); end
    end
  endtask

  task automatic test_start_ignored;
    bit to; int t0; logic b1; int bad;
    run_job(12'h100, 12'h200, 16'd10, 0, 1, 0, to, t0, b1);
    repeat (6) @(negedge clk);
    n_vec++;
    if (to || done_n !== 1) begin n_err++; $display("FAIL ign_done: got %0d expected 1", done_n); end
    n_vec++;
    if (wq.size() !== 3 || dq.size() !== DEPTH || cf_n !== 10) begin
      n_err++; $display("FAIL ign_counts: got %0d/%0d/%0d expected 3/64/10", wq.size(), dq.size(), cf_n);
    end
    bad = 0;
    for (int i = 0; i < dq.size(); i++) if (dq[i] !== mem_f(AW'(12'h200 + i))) bad++;
    n_vec++;
    if (bad != 0 || done_cyc - t0 !== 84 || out_count !== 0) begin
      n_err++; $display("FAIL ign_job: got bad %0d len %0d oc %0d expected 0/84/0", bad, done_cyc - t0, out_count);
    end
  endtask

  task automatic test_reset_midjob;
    bit to; int t0; logic b1; int fc;
    clear_mon();
    @(negedge clk);
    w_base = 12'h100; d_base = 12'h200; compute_cycles = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fc = 0;
    for (int i = 0; i < 300 && fc < 4; i++) begin
      compute_done = compute_fire;
      if (compute_fire) fc++;
      if (fc < 4) @(negedge clk);
    end
    compute_done = 1'b0;
    n_vec++;
    if (fc !== 4 || out_count !== 16'd3 || busy !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: got fc %0d oc %0d busy %b expected 4/3/1", fc, out_count, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, rd_en, buffer_weight_fire, buffer_data_fire, compute_fire} !== 6'b0 ||
        out_count !== '0 || rd_addr !== '0 || weight_in !== '0 || data_in !== '0) begin
      n_err++; $display("FAIL mid_async_clear: got busy %b cf %b oc %0d expected 0/0/0", busy, compute_fire, out_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++;
    if (done_n !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_no_done: got %0d/%b expected 0/0", done_n, busy);
    end
    run_job(12'h100, 12'h200, 16'd0, 0, 0, 0, to, t0, b1);
    n_vec++;
    if (to || cf_n !== 1 || done_n !== 1) begin
      n_err++; $display("FAIL mid_fresh_cc0: got cf %0d done %0d expected 1/1", cf_n, done_n);
    end
  endtask

`ifdef CONV_SEQ_CTRL_HOLD_EN
  task automatic test_hold;
    bit to; int t0; logic b1;
    run_job(12'h100, 12'h200, 16'd10, 0, 0, 3, to, t0, b1);
    n_vec++;
    if (to || cf_n !== 10 || cf_last - cf_first + 1 !== 15) begin
      n_err++; $display("FAIL hold_cfire: got %0d over %0d expected 10 over 15", cf_n, cf_last - cf_first + 1);
    end
    n_vec++;
    if (done_cyc - t0 !== base_len + 5) begin
      n_err++; $display("FAIL hold_done_time: got %0d expected %0d", done_cyc - t0, base_len + 5);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; compute_done = 1'b0;
    w_base = '0; d_base = '0; compute_cycles = '0;
`ifdef CONV_SEQ_CTRL_HOLD_EN
    hold = 1'b0;
`endif
    test_reset();
    test_basic();
    test_out_count();
    test_wrap();
    test_start_ignored();
    test_reset_midjob();
`ifdef CONV_SEQ_CTRL_HOLD_EN
    test_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
